// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM state (IDLE, IF_BUSY, DM_BUSY)
//   *_DEF       : default parameter values used by mem_arbiter
package mem_arb_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision between the fetch and data requesters.
// Data wins a conflict unless fetch has already lost STARVE_MAX times in a row.
//   clk_i, rst_ni   : clock, async active-low reset
//   decide_i        : arbiter is idle and started; a decision is taken this edge
//   if_req_i        : fetch request
//   dm_req_i        : data request
//   pick_if_o       : fetch would be granted (combinational)
//   pick_dm_o       : data would be granted (combinational)
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic decide_i,
    input  logic if_req_i,
    input  logic dm_req_i,
    output logic pick_if_o,
    output logic pick_dm_o
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starved;

    assign starved = (starve_cnt_q == CW'(STARVE_MAX));

    always_comb begin
        pick_if_o    = if_req_i && (!dm_req_i || starved);
        pick_dm_o    = dm_req_i && !pick_if_o;
        starve_cnt_d = starve_cnt_q;
        if (decide_i) begin
            if (pick_if_o) begin
                starve_cnt_d = '0;
            end else if (pick_dm_o && if_req_i && !starved) begin
                // fetch lost a conflict; pick_dm with if_req implies not yet saturated
                starve_cnt_d = starve_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) starve_cnt_q <= '0;
        else         starve_cnt_q <= starve_cnt_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data load/store port onto one
// single-port memory, one outstanding transaction at a time.
//   clk_i, rst_ni                       : clock, async active-low reset
//   start_i                             : sticky enable; no grants until seen high
//   if_req_i, if_addr_i                 : fetch request
//   if_gnt_o, if_rdata_o, if_rvalid_o   : fetch grant pulse and response
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                          : data request
//   dm_gnt_o, dm_rdata_o, dm_rvalid_o   : data grant pulse and completion
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                         : memory request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i              : memory completion and read data
//   busy_o                              : a transaction is outstanding
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_rvalid_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  dm_rvalid_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);

    arb_state_e            state_q, state_d;
    logic                  started_q, started_d;
    logic                  if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic                  if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic                  decide, pick_if, pick_dm;

    assign decide = (state_q == IDLE) && started_q;

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .decide_i  (decide),
        .if_req_i  (if_req_i),
        .dm_req_i  (dm_req_i),
        .pick_if_o (pick_if),
        .pick_dm_o (pick_dm)
    );

    always_comb begin
        state_d     = state_q;
        started_d   = started_q | start_i;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            IDLE: begin
                // requesters hold addr stable until gnt, so capturing at the
                // deciding edge gives the same value as the grant cycle
                if (decide && pick_dm) begin
                    state_d  = DM_BUSY;
                    dm_gnt_d = 1'b1;
                    addr_d   = dm_addr_i;
                    we_d     = dm_we_i;
                    wdata_d  = dm_wdata_i;
                end else if (decide && pick_if) begin
                    state_d  = IF_BUSY;
                    if_gnt_d = 1'b1;
                    addr_d   = if_addr_i;
                    we_d     = 1'b0;
                end
            end
            IF_BUSY: begin
                if (mem_ack_i) begin
                    state_d     = IDLE;
                    if_rdata_d  = mem_rdata_i;
                    if_rvalid_d = 1'b1;
                end
            end
            DM_BUSY: begin
                if (mem_ack_i) begin
                    state_d     = IDLE;
                    dm_rdata_d  = mem_rdata_i;
                    dm_rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            started_q   <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign mem_req_o   = busy_o;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_gnt_o    = if_gnt_q;
    assign dm_gnt_o    = dm_gnt_q;
    assign if_rvalid_o = if_rvalid_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(if_gnt), .if_rdata_o(if_rdata), .if_rvalid_o(if_rvalid),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt), .dm_rdata_o(dm_rdata), .dm_rvalid_o(dm_rvalid),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_glat;
    } vec_t;

    int   n_cmp = 0, n_bad = 0;
    int   ack_lat = 1;
    bit   resp_en = 1'b1;
    bit   sb_en = 1'b1;
    int   rsp_cnt = 0;
    exp_t sb_q[$];
    byte  gnt_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference memory contents
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0]};
    endfunction

    // memory responder: ack after ack_lat cycles of mem_req
    initial forever begin
        @(posedge clk); #1;
        if (mem_ack) begin
            mem_ack = 1'b0;
            rsp_cnt = 0;
        end else if (mem_req && resp_en) begin
            rsp_cnt++;
            if (rsp_cnt >= ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_model(mem_addr);
            end
        end else begin
            rsp_cnt = 0;
        end
    end

    // monitor / scoreboard
    logic        p_req = 0, p_ifg = 0, p_dmg = 0, p_ifv = 0, p_dmv = 0;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_req <= 0; p_ifg <= 0; p_dmg <= 0; p_ifv <= 0; p_dmv <= 0;
        end else begin
            if (p_ifg) chk("if_gnt_pulse", if_gnt, 0);
            if (p_dmg) chk("dm_gnt_pulse", dm_gnt, 0);
            if (p_ifv) chk("if_rvalid_pulse", if_rvalid, 0);
            if (p_dmv) chk("dm_rvalid_pulse", dm_rvalid, 0);
            chk("busy_vs_req", busy, mem_req);
            if (if_gnt || dm_gnt) begin
                chk("gnt_onehot", if_gnt & dm_gnt, 0);
                chk("gnt_with_req", mem_req, 1);
                gnt_log.push_back(dm_gnt ? 8'h44 : 8'h49);
            end
            if (mem_req) begin
                if (!p_req) begin
                    h_addr <= mem_addr; h_we <= mem_we; h_wdata <= mem_wdata;
                    if (sb_en && sb_q.size() > 0) begin
                        chk("mem_addr", mem_addr, sb_q[0].addr);
                        chk("mem_we", mem_we, sb_q[0].we);
                        if (sb_q[0].we) chk("mem_wdata", mem_wdata, sb_q[0].wdata);
                    end
                end else begin
                    chk("hold_addr", mem_addr, h_addr);
                    chk("hold_we", mem_we, h_we);
                    chk("hold_wdata", mem_wdata, h_wdata);
                end
            end
            if (sb_en && (if_rvalid || dm_rvalid)) begin
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rv_port", dm_rvalid, e.dm);
                    if (!e.we) chk(e.dm ? "dm_rdata" : "if_rdata", e.dm ? dm_rdata : if_rdata, e.rdata);
                end
            end
            p_req <= mem_req; p_ifg <= if_gnt; p_dmg <= dm_gnt;
            p_ifv <= if_rvalid; p_dmv <= dm_rvalid;
        end
    end

    task automatic wait_gnt(input bit dm, input int exp, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(dm ? dm_gnt : if_gnt) && n < 40);
        chk(nm, n, exp);
    endtask

    task automatic wait_rv(input bit dm, input int exp);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(dm ? dm_rvalid : if_rvalid) && n < 40);
        chk(dm ? "dm_rv_lat" : "if_rv_lat", n, exp);
    endtask

    task automatic push_exp(input bit dm, input bit we, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.dm = dm; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd_model(a);
        sb_q.push_back(e);
    endtask

    task automatic xfer(input vec_t v);
        @(posedge clk); #1;
        ack_lat = v.lat;
        if (v.dm) begin
            dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1; if_addr = v.addr;
        end
        push_exp(v.dm, v.dm & v.we, v.addr, v.wdata);
        wait_gnt(v.dm, v.exp_glat, "gnt_lat");
        @(posedge clk); #1;
        if (v.dm) dm_req = 0; else if_req = 0;
        wait_rv(v.dm, v.lat);
    endtask

    // fetch raised without start: no grant; then pulse start
    task automatic start_then_fetch(input logic [31:0] a, input int lat);
        @(posedge clk); #1;
        ack_lat = lat;
        if_req = 1; if_addr = a;
        push_exp(0, 0, a, 0);
        repeat (5) begin @(negedge clk); chk("no_gnt_before_start", if_gnt, 0); end
        @(posedge clk); #1;
        start = 1;
        fork begin @(posedge clk); #1 start = 0; end join_none
        wait_gnt(0, 3, "gnt_after_start");
        @(posedge clk); #1;
        if_req = 0;
        wait_rv(0, lat);
        @(negedge clk);
        chk("if_rdata_hold", if_rdata, rd_model(a));
    endtask

    vec_t  vecs[6];
    string exp_ord = "DDDDIDDDDI";

    initial begin
        vecs[0] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4, 2};
        vecs[1] = '{1, 0, 32'h0000_0100, 32'h0,         1, 2};
        vecs[2] = '{0, 0, 32'h2000_0004, 32'h0,         2, 2};
        vecs[3] = '{1, 0, 32'hFFFF_FFFC, 32'h0,         5, 2};
        vecs[4] = '{0, 0, 32'h0000_0000, 32'h0,         1, 2};
        vecs[5] = '{1, 1, 32'h0000_0008, 32'h1234_5678, 1, 2};

        // reset state
        #12;
        chk("rst_if_gnt", if_gnt, 0);       chk("rst_dm_gnt", dm_gnt, 0);
        chk("rst_if_rvalid", if_rvalid, 0); chk("rst_dm_rvalid", dm_rvalid, 0);
        chk("rst_mem_req", mem_req, 0);     chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);           chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0); chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        @(posedge clk); #1 rst_n = 1;

        // start gating + fetch 0x10 with 3-cycle memory
        start_then_fetch(32'h10, 3);

        // table-driven single transactions
        foreach (vecs[i]) xfer(vecs[i]);

        // back-to-back: ack the cycle after grant, next dm_req already pending
        @(posedge clk); #1;
        ack_lat = 2;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        push_exp(1, 0, 32'h300, 0);
        wait_gnt(1, 2, "b2b_gnt1");
        @(posedge clk); #1;
        dm_addr = 32'h304;
        push_exp(1, 0, 32'h304, 0);
        wait_rv(1, 2);
        @(negedge clk);
        chk("b2b_gnt2", dm_gnt, 1);
        @(posedge clk); #1;
        dm_req = 0;
        wait_rv(1, 2);

        // starvation: both held continuously
        @(posedge clk); #1;
        sb_en = 0; ack_lat = 1;
        gnt_log.delete();
        if_req = 1; if_addr = 32'h40;
        dm_req = 1; dm_we = 0; dm_addr = 32'h80;
        begin
            int n = 0;
            while (gnt_log.size() < 10 && n < 400) begin @(negedge clk); n++; end
        end
        @(posedge clk); #1;
        if_req = 0; dm_req = 0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++)
            chk("starve_order", (i < gnt_log.size()) ? gnt_log[i] : 8'h0, exp_ord[i]);
        sb_en = 1;

        // reset during DM_BUSY before ack
        @(posedge clk); #1;
        resp_en = 0;
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hCAFE_F00D;
        push_exp(1, 1, 32'h200, 32'hCAFE_F00D);
        wait_gnt(1, 2, "rst_case_gnt");
        @(posedge clk); #1;
        dm_req = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_mem_req", mem_req, 0);   chk("midrst_busy", busy, 0);
        chk("midrst_mem_we", mem_we, 0);     chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1; resp_en = 1;
        repeat (10) begin
            @(negedge clk);
            chk("no_rv_after_rst", dm_rvalid, 0);
            chk("idle_after_rst", mem_req, 0);
        end

        // start required again after reset
        start_then_fetch(32'h44, 2);

        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 32: width of read and write data.
REQ-002 SHALL take parameter ADDR_WIDTH, default 32: width of byte addresses.
REQ-003 SHALL take parameter STARVE_MAX, default 4: the number of consecutive data wins allowed against a pending fetch.
REQ-004 SHALL have port clk  in  1: sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1: enable; no grant is issued before start has been sampled high.
REQ-007 SHALL have ports if_req in 1, if_addr in ADDR_WIDTH: instruction-fetch read request.
REQ-008 SHALL have ports if_gnt out 1, if_rdata out DATA_WIDTH, if_rvalid out 1: fetch grant pulse and response.
REQ-009 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in ADDR_WIDTH, dm_wdata in DATA_WIDTH: data load/store request.
REQ-010 SHALL have ports dm_gnt out 1, dm_rdata out DATA_WIDTH, dm_rvalid out 1: data grant pulse and response (completion).
REQ-011 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_WIDTH, mem_wdata out DATA_WIDTH: shared single-port memory request.
REQ-012 SHALL have ports mem_ack in 1, mem_rdata in DATA_WIDTH: memory completion pulse and read data; latency is 1 or more cycles.
REQ-013 SHALL have port busy  out 1: a transaction is outstanding.

Function
REQ-014 SHALL implement the FSM IDLE, IF_BUSY, DM_BUSY, with at most one outstanding memory transaction.
REQ-015 SHALL register a sticky started flag, set on the first clock edge where start is 1; while the flag is clear, the FSM SHALL remain in IDLE.
REQ-016 SHALL, in IDLE with started set, take the following registered decision at the clock edge: dm_req only goes to DM_BUSY; if_req only goes to IF_BUSY; both requests follow REQ-017; no request stays in IDLE.
REQ-017 SHALL resolve a conflict in favour of data, except when starve_cnt equals STARVE_MAX, in which case fetch wins.
REQ-018 SHALL maintain starve_cnt, 0 to STARVE_MAX: it increments, saturating, when data wins while if_req is 1; it clears when fetch is granted.
REQ-019 SHALL, on entering a BUSY state, pulse the owner's gnt for exactly one cycle.
REQ-020 SHALL, in that same grant cycle, capture the owner's addr, we and wdata into registers that drive mem_*; the fetch path SHALL drive mem_we as 0.
REQ-021 SHALL hold mem_req at 1 and the mem_* outputs stable throughout BUSY until mem_ack is sampled 1.
REQ-022 SHALL, on the edge where mem_ack is 1 in BUSY, go to IDLE, register mem_rdata into the owner's rdata, and pulse the owner's rvalid for one cycle; a write completion SHALL pulse dm_rvalid the same way.
REQ-023 SHALL ignore mem_ack when in IDLE.
REQ-024 SHALL ignore if_req and dm_req while in BUSY; requesters hold req and address stable until their gnt, then deassert.
REQ-025 SHALL give the following latency: request sampled in IDLE at edge N, gnt and mem_req high in cycle N+1; mem_ack at edge M, rvalid in cycle M+1.
REQ-026 SHALL permit back-to-back operation: a request present at edge M+1 is granted in cycle M+2.
REQ-027 SHALL hold rdata until the next response to the same port; rdata is valid only with rvalid.
REQ-028 SHALL drive busy as 1 exactly when the state is IF_BUSY or DM_BUSY.

Reset
REQ-029 SHALL, on rst_n low and asynchronously, force the state to IDLE, started to 0, starve_cnt to 0, and all gnt, rvalid, mem_req, mem_we and busy outputs to 0.
REQ-030 SHALL force the address, wdata and rdata registers to 0 on reset.
REQ-031 SHALL abandon an in-flight transaction on reset mid-operation; after release, no rvalid SHALL be issued for it, and start SHALL be required again.

Structure
REQ-032 SHALL place the state enum (IDLE, IF_BUSY, DM_BUSY) and the default-width constants in the shared package mem_arb_pkg.
REQ-033 SHALL contain one sub-module, mem_arb_pick, holding the combinational priority decision and the starve_cnt register.
REQ-034 SHALL keep the total implementation within 120 to 400 lines of RTL.

Verification
REQ-035 SHALL cover this scenario: if_req is raised before start -> no if_gnt is issued; after start=1, if_gnt arrives 1 cycle after the request is sampled.
REQ-036 SHALL cover this scenario: a fetch at if_addr=0x10 with mem_ack after 3 cycles and mem_rdata=0x00500093 -> if_rvalid is 1 for one cycle and if_rdata=0x00500093.
REQ-037 SHALL cover this scenario: if_req and dm_req are held continuously with STARVE_MAX=4 -> the grant order is DM,DM,DM,DM,IF,DM,... repeating.
REQ-038 SHALL cover this scenario: a store with dm_addr=0x100 and dm_wdata=0xDEADBEEF -> mem_we=1 and mem_addr/mem_wdata are stable until mem_ack, then dm_rvalid pulses.
REQ-039 SHALL cover this scenario: rst_n is pulled low during DM_BUSY before mem_ack -> mem_req drops immediately, and no dm_rvalid appears after release.
REQ-040 SHALL cover this scenario: mem_ack arrives the cycle after the grant and a new dm_req is already pending -> the next dm_gnt comes 1 cycle after dm_rvalid.
